// File: rtl/multi_delay.sv
// N-channel race-logic delay: each channel captures its first input spike per
// gamma window and re-emits it a captured number of cycles later, as a step or pulse.
module multi_delay #(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 4,
  parameter int NUM_CH            = 4,
  parameter int MODE              = 0,
  parameter int DW                = $clog2(GAMMA_CYCLE_WIDTH)
) (
  input  logic                                   aclk,
  input  logic                                   grst,
  input  logic [NUM_CH-1:0]                      in,
  input  logic [NUM_CH*DW-1:0]                   delay,
  output logic [NUM_CH-1:0]                      out,
  output logic [NUM_CH-1:0]                      ovf,
  output logic [$clog2(GAMMA_CYCLE_WIDTH+1)-1:0] gamma_cnt
);

  localparam int GW  = $clog2(GAMMA_CYCLE_WIDTH + 1);
  // Fire time t+d+1 can reach nearly three windows when the window is not a power of two.
  localparam int FW  = GW + 2;
  localparam int PCW = $clog2(PULSE_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, COUNT, FIRE, DONE} ch_state_t;

  logic [GW-1:0] gamma_cnt_reg;
  logic          window_open;

  always_ff @(posedge aclk) begin
    if (grst) begin
      gamma_cnt_reg <= '0;
    end else if (gamma_cnt_reg != GW'(GAMMA_CYCLE_WIDTH)) begin
      gamma_cnt_reg <= gamma_cnt_reg + GW'(1);
    end
  end

  assign window_open = (gamma_cnt_reg < GW'(GAMMA_CYCLE_WIDTH));
  assign gamma_cnt   = gamma_cnt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      ch_state_t      state_reg, state_next;
      logic [DW-1:0]  cnt_reg, cnt_next;
      logic [PCW-1:0] pcnt_reg, pcnt_next;
      logic           out_reg, out_next;
      logic           ovf_reg, ovf_next;
      logic [DW-1:0]  d_in;
      logic [FW-1:0]  fire_at;

      assign d_in    = delay[gi*DW +: DW];
      assign fire_at = FW'(gamma_cnt_reg) + FW'(d_in) + FW'(1);

      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pcnt_next  = pcnt_reg;
        ovf_next   = ovf_reg;
        case (state_reg)
          IDLE: begin
            if (in[gi] && window_open) begin
              if (fire_at < FW'(GAMMA_CYCLE_WIDTH)) begin
                if (d_in == '0) begin
                  state_next = FIRE;
                  pcnt_next  = PCW'(PULSE_WIDTH - 1);
                end else begin
                  state_next = COUNT;
                  cnt_next   = d_in;
                end
              end else begin
                state_next = DONE;
                ovf_next   = 1'b1;
              end
            end
          end
          COUNT: begin
            // Reaching zero on this edge means the output is high next cycle.
            if (cnt_reg == DW'(1)) begin
              state_next = FIRE;
              cnt_next   = '0;
              pcnt_next  = PCW'(PULSE_WIDTH - 1);
            end else begin
              cnt_next = cnt_reg - DW'(1);
            end
          end
          FIRE: begin
            if (MODE == 1) begin
              if (pcnt_reg == '0) begin
                state_next = DONE;
              end else begin
                pcnt_next = pcnt_reg - PCW'(1);
              end
            end
          end
          default: begin
          end
        endcase
        out_next = (state_next == FIRE);
      end

      always_ff @(posedge aclk) begin
        if (grst) begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
          pcnt_reg  <= '0;
          out_reg   <= 1'b0;
          ovf_reg   <= 1'b0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
          pcnt_reg  <= pcnt_next;
          out_reg   <= out_next;
          ovf_reg   <= ovf_next;
        end
      end

      assign out[gi] = out_reg;
      assign ovf[gi] = ovf_reg;
    end
  endgenerate

endmodule
